// File: rtl/led_fader_pkg.sv
// Shared constants and types for the LED fader: level width, PWM period limits
// and the per-channel fade state encoding.
package led_fader_pkg;

  localparam int LEVEL_W   = 8;
  localparam int PWM_MAX   = 254;
  localparam int LEVEL_MAX = 255;

  typedef enum logic [1:0] {
    OFF,
    RISING,
    ON,
    FALLING
  } fade_state_t;

endpackage

// File: rtl/led_fader_channel.sv
// One fader channel: saturating brightness level, period-aligned shadow copy
// of the level, and the registered PWM compare that drives the pin.
module led_fader_channel
  import led_fader_pkg::*;
#(
  parameter int RAMP_STEP = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               req,
  input  logic               tick,
  input  logic               load,
  input  logic [LEVEL_W-1:0] pwm_cnt,
  output logic [LEVEL_W-1:0] level,
  output logic               led_out
);

  localparam logic [LEVEL_W-1:0] STEP = LEVEL_W'(RAMP_STEP);

  fade_state_t        state;
  logic [LEVEL_W-1:0] level_next;
  logic [LEVEL_W-1:0] shadow;

  // Widen by one bit so an overflow past full scale clamps instead of wrapping.
  function automatic logic [LEVEL_W-1:0] sat_up(input logic [LEVEL_W-1:0] a);
    logic [LEVEL_W:0] sum;
    sum = {1'b0, a} + {1'b0, STEP};
    if (sum > (LEVEL_W+1)'(LEVEL_MAX)) begin
      return LEVEL_W'(LEVEL_MAX);
    end
    return sum[LEVEL_W-1:0];
  endfunction

  // A borrow out of the widened difference means the step would go below zero.
  function automatic logic [LEVEL_W-1:0] sat_down(input logic [LEVEL_W-1:0] a);
    logic [LEVEL_W:0] diff;
    diff = {1'b0, a} - {1'b0, STEP};
    if (diff[LEVEL_W]) begin
      return '0;
    end
    return diff[LEVEL_W-1:0];
  endfunction

  // Decode the fade state from request and level, then pick the next level on a tick.
  always_comb begin
    state      = OFF;
    level_next = level;
    if (req) begin
      state = (level == LEVEL_W'(LEVEL_MAX)) ? ON : RISING;
    end else begin
      state = (level == '0) ? OFF : FALLING;
    end
    if (tick) begin
      case (state)
        RISING:  level_next = sat_up(level);
        FALLING: level_next = sat_down(level);
        default: level_next = level;
      endcase
    end
  end

  // Level, shadow and pin compare; shadow samples the pre-tick level at the period end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level   <= '0;
      shadow  <= '0;
      led_out <= 1'b0;
    end else begin
      level <= level_next;
      if (load) begin
        shadow <= level;
      end
      led_out <= enable && (pwm_cnt < shadow);
    end
  end

endmodule

// File: rtl/led_fader.sv
// LED fader top: registers the PIO requests, runs the ramp prescaler and the
// shared PWM counter, fans out to one fader channel per LED and reports busy.
module led_fader
  import led_fader_pkg::*;
#(
  parameter int N_LEDS    = 8,
  parameter int STEP_DIV  = 1000,
  parameter int RAMP_STEP = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [N_LEDS-1:0] led_req,
  output logic [N_LEDS-1:0] led_out,
  output logic              busy
);

  localparam int PRE_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;

  logic [N_LEDS-1:0]  req_q;
  logic [PRE_W-1:0]   presc;
  logic [LEVEL_W-1:0] pwm_cnt;
  logic               tick;
  logic               load;
  logic               any_diff;
  logic [LEVEL_W-1:0] levels [N_LEDS];

  // Both strobes are gated by enable so levels and shadows freeze while disabled.
  assign tick = enable && (presc == PRE_W'(STEP_DIV - 1));
  assign load = enable && (pwm_cnt == LEVEL_W'(PWM_MAX));

  // Request capture plus the free-running prescaler and PWM counter (held while disabled).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q   <= '0;
      presc   <= '0;
      pwm_cnt <= '0;
    end else begin
      req_q <= led_req;
      if (enable) begin
        presc   <= tick ? '0 : presc + PRE_W'(1);
        pwm_cnt <= load ? '0 : pwm_cnt + LEVEL_W'(1);
      end
    end
  end

  // Any channel whose level has not yet reached its full-on / full-off target.
  always_comb begin
    any_diff = 1'b0;
    for (int i = 0; i < N_LEDS; i++) begin
      if (levels[i] != (req_q[i] ? LEVEL_W'(LEVEL_MAX) : LEVEL_W'(0))) begin
        any_diff = 1'b1;
      end
    end
  end

  // Busy is registered, so it trails the levels by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
    end else begin
      busy <= any_diff;
    end
  end

  for (genvar g = 0; g < N_LEDS; g++) begin : gen_ch
    led_fader_channel #(
      .RAMP_STEP(RAMP_STEP)
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .enable (enable),
      .req    (req_q[g]),
      .tick   (tick),
      .load   (load),
      .pwm_cnt(pwm_cnt),
      .level  (levels[g]),
      .led_out(led_out[g])
    );
  end

endmodule

// File: tb/tb_led_fader.sv
// Bench for led_fader: a cycle model pushes expected outputs and levels into a
// scoreboard every clock, compared half a cycle later, plus directed checks.
`timescale 1ns/1ps
module tb_led_fader;

  localparam int N  = 8;
  localparam int SD = 4;
  localparam int RS = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] led_req = 8'h00;
  logic [7:0] led_out;
  logic       busy;
  logic [7:0] led_out3;
  logic       busy3;

  int check_cnt = 0;
  int fail_cnt  = 0;

  always #5 clk = ~clk;

  led_fader #(.N_LEDS(N), .STEP_DIV(SD), .RAMP_STEP(RS)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .led_req(led_req), .led_out(led_out), .busy(busy)
  );

  led_fader #(.N_LEDS(N), .STEP_DIV(SD), .RAMP_STEP(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .led_req(led_req), .led_out(led_out3), .busy(busy3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model of the fader, written from the behavioural description.
  typedef struct packed {
    logic [7:0]  led;
    logic        bsy;
    logic [63:0] lv;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_req = 8'h00;
  logic [7:0] m_led = 8'h00;
  logic       m_busy = 1'b0;
  int         m_presc = 0;
  int         m_pwm = 0;
  int         m_level [N];
  int         m_shadow[N];

  always @(posedge clk or negedge reset_n) begin
    exp_t e;
    logic t, ld, nb;
    logic [7:0] nl;
    int tgt;
    if (!reset_n) begin
      m_req = 8'h00; m_led = 8'h00; m_busy = 1'b0; m_presc = 0; m_pwm = 0;
      for (int i = 0; i < N; i++) begin m_level[i] = 0; m_shadow[i] = 0; end
    end else begin
      t  = enable && (m_presc == SD - 1);
      ld = enable && (m_pwm == 254);
      nb = 1'b0;
      nl = 8'h00;
      for (int i = 0; i < N; i++) begin
        tgt = m_req[i] ? 255 : 0;
        if (m_level[i] != tgt) nb = 1'b1;
        nl[i] = enable && (m_pwm < m_shadow[i]);
        if (ld) m_shadow[i] = m_level[i];
        if (t) begin
          if (m_req[i]) m_level[i] = (m_level[i] + RS > 255) ? 255 : m_level[i] + RS;
          else          m_level[i] = (m_level[i] - RS < 0)   ? 0   : m_level[i] - RS;
        end
      end
      if (enable) begin
        m_presc = (m_presc == SD - 1) ? 0 : m_presc + 1;
        m_pwm   = (m_pwm == 254) ? 0 : m_pwm + 1;
      end
      m_req  = led_req;
      m_led  = nl;
      m_busy = nb;
      e.led = m_led;
      e.bsy = m_busy;
      for (int i = 0; i < N; i++) e.lv[i*8 +: 8] = 8'(m_level[i]);
      exp_q.push_back(e);
    end
  end

  // Scoreboard: pop the expectation for the last edge and compare away from it.
  always @(negedge clk) begin
    exp_t e;
    logic [63:0] lv;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int i = 0; i < N; i++) lv[i*8 +: 8] = dut.levels[i];
      check("sb_led_out", 64'(led_out), 64'(e.led));
      check("sb_busy", 64'(busy), 64'(e.bsy));
      check("sb_levels", lv, e.lv);
    end
  end

  task automatic wait_level(input int ch, input int val, input int budget, input string tag);
    int n = 0;
    while (int'(dut.levels[ch]) != val && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(n < budget), 64'd1);
  endtask

  initial begin
    int n;
    int hi;
    int exp_duty;

    // Reset state.
    reset_n = 1'b0; enable = 1'b0; led_req = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_led_out", 64'(led_out), 64'h00);
    check("rst_busy", 64'(busy), 64'h0);
    reset_n = 1'b1;
    enable  = 1'b1;

    // Ramp up channel 0; busy drops exactly one cycle after 255.
    led_req = 8'h01;
    wait_level(0, 255, 400, "ramp_up_reach");
    check("ramp_busy_before", 64'(busy), 64'h1);
    @(negedge clk);
    check("ramp_busy_after", 64'(busy), 64'h0);
    check("ramp_level_255", 64'(dut.levels[0]), 64'd255);

    // RAMP_STEP=3 rise ends 252 then 255.
    n = 0;
    while (dut3.levels[0] != 8'd252 && n < 200) begin @(negedge clk); n++; end
    check("rs3_reach_252", 64'(n < 200), 64'd1);
    n = 0;
    while (dut3.levels[0] == 8'd252 && n < 10) begin @(negedge clk); n++; end
    check("rs3_final", 64'(dut3.levels[0]), 64'd255);

    // Full-on pin: constant high over a complete PWM period.
    repeat (300) @(negedge clk);
    hi = 0;
    repeat (255) begin @(negedge clk); hi += int'(led_out[0]); end
    check("full_on_duty", 64'(hi), 64'd255);

    // Fall to 0, then reversal at 100.
    led_req = 8'h00;
    wait_level(0, 0, 400, "fall_reach_0");
    led_req = 8'h01;
    wait_level(0, 100, 200, "rev_reach_100");
    led_req = 8'h00;
    wait_level(0, 0, 200, "rev_reach_0");
    repeat (20) @(negedge clk);
    check("rev_no_undershoot", 64'(dut.levels[0]), 64'd0);
    check("rev_busy_idle", 64'(busy), 64'h0);

    // Enable dropped at level 60: pin forced low, level frozen, resumes at 64.
    led_req = 8'h01;
    wait_level(0, 60, 200, "en_reach_60");
    enable = 1'b0;
    @(negedge clk);
    check("en_led_off", 64'(led_out), 64'h00);
    check("en_busy_kept", 64'(busy), 64'h1);
    repeat (20) @(negedge clk);
    check("en_level_frozen", 64'(dut.levels[0]), 64'd60);
    enable = 1'b1;
    n = 0;
    while (dut.levels[0] == 8'd60 && n < 10) begin @(negedge clk); n++; end
    check("en_resume", 64'(dut.levels[0]), 64'd64);

    // Hold at 128 with enable low, then measure one whole PWM period.
    wait_level(0, 128, 200, "duty_reach_128");
    enable  = 1'b0;
    led_req = 8'h00;
    repeat (10) @(negedge clk);
    check("duty_hold_128", 64'(dut.levels[0]), 64'd128);
    enable = 1'b1;
    n = 0;
    while (dut.pwm_cnt != 8'd0 && n < 300) begin @(negedge clk); n++; end
    check("duty_wrap_seen", 64'(n < 300), 64'd1);
    exp_duty = m_shadow[0];
    hi = 0;
    repeat (255) begin @(negedge clk); hi += int'(led_out[0]); end
    check("duty_count", 64'(hi), 64'(exp_duty));

    // Asynchronous reset mid-ramp at level 100.
    led_req = 8'h01;
    wait_level(0, 100, 600, "rst_reach_100");
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_led", 64'(led_out), 64'h00);
    check("async_rst_busy", 64'(busy), 64'h0);
    check("async_rst_level", 64'(dut.levels[0]), 64'd0);
    @(negedge clk);
    led_req = 8'hA5;
    @(negedge clk);
    reset_n = 1'b1;

    // Independence: 0xA5 ramps only channels 0, 2, 5, 7.
    repeat (700) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("indep_level_%0d", i), 64'(dut.levels[i]),
            ((8'hA5 >> i) & 1) != 0 ? 64'd255 : 64'd0);
    end
    check("indep_led_out", 64'(led_out), 64'hA5);
    check("indep_busy", 64'(busy), 64'h0);

    @(negedge clk);
    $display("%0d/%0d checks passed", check_cnt - fail_cnt, check_cnt);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
